// File: rtl/ldpc_3gpp_dec_vnode_engine_pkg.sv
// Shared vnode decoder types: node/LLR/accumulator widths, saturation limit, FSM states.
// Widths here are the default build; the engine derives its own from its parameters.
package ldpc_3gpp_dec_vnode_engine_pkg;

  localparam int cLLR_W   = 4;
  localparam int cNODE_W  = 5;
  localparam int cROW_MAX = 46;
  localparam int cACC_W   = cNODE_W + $clog2(cROW_MAX + 1) + 1;

  typedef logic signed [cLLR_W-1:0]  llr_t;
  typedef logic signed [cNODE_W-1:0] cnode_t;
  typedef logic signed [cNODE_W-1:0] node_t;
  typedef logic signed [cACC_W-1:0]  vacc_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_FLUSH
  } vnode_state_t;

  // Symmetric saturation magnitude for a w-bit signed node.
  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int acc_width(input int node_w, input int row_max);
    return node_w + $clog2(row_max + 1) + 1;
  endfunction

endpackage

// File: rtl/ldpc_3gpp_dec_vnode_buf.sv
// Column replay buffer: one write port, one registered read port, contents never reset.
module ldpc_3gpp_dec_vnode_buf #(
  parameter int pNODE_W  = 5,
  parameter int pROW_MAX = 46,
  parameter int pADDR_W  = 6
) (
  input  logic               i_clk,
  input  logic               i_clkena,
  input  logic               i_wr,
  input  logic [pADDR_W-1:0] i_waddr,
  input  logic [pNODE_W-1:0] i_wdata,
  input  logic               i_rd,
  input  logic [pADDR_W-1:0] i_raddr,
  output logic [pNODE_W-1:0] o_rdata
);

  logic [pNODE_W-1:0] r_mem [pROW_MAX];
  logic [pNODE_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_clkena) begin
      if (i_wr) r_mem[i_waddr] <= i_wdata;
      if (i_rd) r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ldpc_3gpp_dec_vnode_engine.sv
// Variable-node engine: accumulates llr + cnodes of a column, then replays sat(acc - cnode[j]).
// Optional hard-decision output enabled by defining LDPC_3GPP_DEC_VNODE_HD_EN.
module ldpc_3gpp_dec_vnode_engine
  import ldpc_3gpp_dec_vnode_engine_pkg::*;
#(
  parameter int pLLR_W   = 4,
  parameter int pNODE_W  = 5,
  parameter int pROW_MAX = 46
) (
  input  logic                      iclk,
  input  logic                      ireset_n,
  input  logic                      iclkena,
  input  logic                      ival,
  input  logic                      isop,
  input  logic                      ieop,
  input  logic signed [pNODE_W-1:0] icnode,
  input  logic signed [pLLR_W-1:0]  illr,
  output logic                      ordy,
  output logic                      oval,
  output logic                      osop,
  output logic                      oeop,
  output logic signed [pNODE_W-1:0] ovnode,
  output logic                      ohd,
  output logic                      ooverflow
);

  localparam int cCNT_W  = $clog2(pROW_MAX + 1);
  localparam int cADDR_W = (pROW_MAX > 1) ? $clog2(pROW_MAX) : 1;
  localparam int cVACC_W = acc_width(pNODE_W, pROW_MAX);
  localparam logic signed [cVACC_W:0] cSAT_P = (cVACC_W + 1)'(sat_max(pNODE_W));
  localparam logic signed [cVACC_W:0] cSAT_N = -cSAT_P;

  vnode_state_t               r_state, w_state_nxt;
  logic [cCNT_W-1:0]          r_cnt, w_cnt_nxt, r_rd_ptr;
  logic signed [cVACC_W-1:0]  r_acc, w_llr_ext, w_node_ext;
  logic                       w_start, w_add, w_wr, w_close, w_ovf, w_rd;
  logic [cADDR_W-1:0]         w_wr_addr;
  logic signed [pNODE_W-1:0]  w_rdata, w_sat, r_ovnode;
  logic signed [cVACC_W:0]    w_diff;
  logic                       r_rd_vld, r_rd_sop, r_rd_eop;
  logic                       r_oval, r_osop, r_oeop, r_ovf;

  assign w_llr_ext  = {{(cVACC_W - pLLR_W){illr[pLLR_W-1]}}, illr};
  assign w_node_ext = {{(cVACC_W - pNODE_W){icnode[pNODE_W-1]}}, icnode};
  assign ordy       = (r_state != ST_FLUSH);
  assign w_wr_addr  = w_start ? '0 : r_cnt[cADDR_W-1:0];

  always_comb begin
    w_state_nxt = r_state;
    w_start     = ival & ordy & isop;
    w_add       = ival & ~isop & (r_state == ST_ACC);
    w_wr        = w_start | w_add;
    w_cnt_nxt   = w_start ? cCNT_W'(1) : r_cnt + cCNT_W'(1);
    // Reaching pROW_MAX beats closes the column as if ieop had arrived.
    w_close     = w_wr & (ieop | (w_cnt_nxt == cCNT_W'(pROW_MAX)));
    w_ovf       = w_wr & ~ieop & (w_cnt_nxt == cCNT_W'(pROW_MAX));
    w_rd        = (r_state == ST_FLUSH) & (r_rd_ptr < r_cnt);
    case (r_state)
      ST_IDLE:  if (w_start) w_state_nxt = w_close ? ST_FLUSH : ST_ACC;
      ST_ACC:   if (w_close) w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (r_oval & r_oeop) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_diff = {r_acc[cVACC_W-1], r_acc}
                - {{(cVACC_W + 1 - pNODE_W){w_rdata[pNODE_W-1]}}, w_rdata};

  always_comb begin
    w_sat = w_diff[pNODE_W-1:0];
    if (w_diff > cSAT_P)      w_sat = cSAT_P[pNODE_W-1:0];
    else if (w_diff < cSAT_N) w_sat = cSAT_N[pNODE_W-1:0];
  end

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_rd_ptr <= '0;
      r_rd_vld <= 1'b0;
      r_rd_sop <= 1'b0;
      r_rd_eop <= 1'b0;
      r_oval   <= 1'b0;
      r_osop   <= 1'b0;
      r_oeop   <= 1'b0;
      r_ovnode <= '0;
      r_ovf    <= 1'b0;
    end else if (iclkena) begin
      r_state <= w_state_nxt;
      r_ovf   <= w_ovf;
      if (w_wr) begin
        r_cnt <= w_cnt_nxt;
        r_acc <= w_start ? (w_llr_ext + w_node_ext) : (r_acc + w_node_ext);
      end
      // Two-stage replay: buffer read, then subtract/saturate into the output register.
      r_rd_ptr <= (r_state == ST_FLUSH) ? r_rd_ptr + cCNT_W'(w_rd) : '0;
      r_rd_vld <= w_rd;
      r_rd_sop <= (r_rd_ptr == '0);
      r_rd_eop <= (r_rd_ptr == r_cnt - cCNT_W'(1));
      r_oval   <= r_rd_vld;
      r_osop   <= r_rd_sop;
      r_oeop   <= r_rd_eop;
      r_ovnode <= w_sat;
    end
  end

`ifdef LDPC_3GPP_DEC_VNODE_HD_EN
  logic r_hd;

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) r_hd <= 1'b0;
    else if (iclkena) r_hd <= r_acc[cVACC_W-1];
  end

  assign ohd = r_hd;
`else
  assign ohd = 1'b0;
`endif

  assign oval      = r_oval;
  assign osop      = r_osop;
  assign oeop      = r_oeop;
  assign ovnode    = r_ovnode;
  assign ooverflow = r_ovf;

  ldpc_3gpp_dec_vnode_buf #(
    .pNODE_W  (pNODE_W),
    .pROW_MAX (pROW_MAX),
    .pADDR_W  (cADDR_W)
  ) u_buf (
    .i_clk    (iclk),
    .i_clkena (iclkena),
    .i_wr     (w_wr),
    .i_waddr  (w_wr_addr),
    .i_wdata  (icnode),
    .i_rd     (w_rd),
    .i_raddr  (r_rd_ptr[cADDR_W-1:0]),
    .o_rdata  (w_rdata)
  );

endmodule

// File: tb/tb_ldpc_3gpp_dec_vnode_engine.sv
// Scoreboard bench for the vnode engine: a column model pushes expected beats, a monitor pops them.
module tb_ldpc_3gpp_dec_vnode_engine;

  localparam int LLR_W   = 4;
  localparam int NODE_W  = 5;
  localparam int ROW_MAX = 46;
  localparam int SMAX    = (1 << (NODE_W - 1)) - 1;
`ifdef LDPC_3GPP_DEC_VNODE_HD_EN
  localparam bit HD_EN = 1'b1;
`else
  localparam bit HD_EN = 1'b0;
`endif

  logic iclk = 1'b0;
  logic ireset_n = 1'b0;
  logic iclkena = 1'b1;
  logic ival = 1'b0, isop = 1'b0, ieop = 1'b0;
  logic signed [NODE_W-1:0] icnode = '0;
  logic signed [LLR_W-1:0]  illr = '0;
  logic ordy, oval, osop, oeop, ohd, ooverflow;
  logic signed [NODE_W-1:0] ovnode;

  ldpc_3gpp_dec_vnode_engine #(
    .pLLR_W   (LLR_W),
    .pNODE_W  (NODE_W),
    .pROW_MAX (ROW_MAX)
  ) dut (
    .iclk      (iclk),
    .ireset_n  (ireset_n),
    .iclkena   (iclkena),
    .ival      (ival),
    .isop      (isop),
    .ieop      (ieop),
    .icnode    (icnode),
    .illr      (illr),
    .ordy      (ordy),
    .oval      (oval),
    .osop      (osop),
    .oeop      (oeop),
    .ovnode    (ovnode),
    .ohd       (ohd),
    .ooverflow (ooverflow)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    int v;
    bit sop;
    bit eop;
    bit hd;
  } exp_t;

  exp_t sb[$];
  int   m_buf[$];
  int   m_acc = 0;
  bit   m_in_col = 1'b0;
  bit   m_ovf = 1'b0;
  int   m_close = 0;
  int   m_rel = 0;
  bit   m_done = 1'b0;
  bit   en_at_edge = 1'b0;
  int   cyc = 0;
  int   m_eop_cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check_val(input string tag, input logic signed [31:0] obs,
                           input logic signed [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic int sat(input int x);
    if (x > SMAX) return SMAX;
    if (x < -SMAX) return -SMAX;
    return x;
  endfunction

  // Column model: accumulate, and on close push one expected beat per stored cnode.
  task automatic model_beat(input bit s, input bit e, input int cn, input int lr, output bit ovf);
    exp_t x;
    ovf = 1'b0;
    if (s) begin
      m_buf.delete();
      m_acc = lr + cn;
      m_buf.push_back(cn);
      m_in_col = 1'b1;
    end else if (m_in_col) begin
      m_acc += cn;
      m_buf.push_back(cn);
    end else begin
      return;
    end
    if (e || m_buf.size() == ROW_MAX) begin
      ovf = !e;
      for (int j = 0; j < m_buf.size(); j++) begin
        x.v   = sat(m_acc - m_buf[j]);
        x.sop = (j == 0);
        x.eop = (j == m_buf.size() - 1);
        x.hd  = HD_EN && (m_acc < 0);
        sb.push_back(x);
      end
      m_in_col  = 1'b0;
      m_close++;
      m_eop_cyc = cyc;
    end
  endtask

  task automatic drive(input bit v, input bit s, input bit e, input int cn, input int lr,
                       input bit en, output bit acc);
    bit ovf, rdy;
    ival = v; isop = s; ieop = e;
    icnode = NODE_W'(cn);
    illr = LLR_W'(lr);
    iclkena = en;
    @(negedge iclk); #1;
    rdy = (m_close == m_rel);
    check_val("ordy", ordy, rdy);
    acc = v && en && rdy;
    ovf = 1'b0;
    if (acc) model_beat(s, e, cn, lr, ovf);
    @(posedge iclk); #1;
    if (en) m_ovf = ovf;
    check_val("ooverflow", ooverflow, m_ovf);
    ival = 1'b0; isop = 1'b0; ieop = 1'b0;
  endtask

  task automatic send(input bit s, input bit e, input int cn, input int lr);
    bit a;
    int tries;
    tries = 0;
    do begin
      drive(1'b1, s, e, cn, lr, 1'b1, a);
      tries++;
    end while (!a && tries < 300);
    if (!a) check_val("accept_timeout", tries, 0);
  endtask

  task automatic send_col(input int lr, input int c[$]);
    for (int i = 0; i < c.size(); i++) send(i == 0, i == c.size() - 1, c[i], lr);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, a);
  endtask

  task automatic wait_drain();
    bit a;
    int k;
    k = 0;
    while ((sb.size() != 0 || m_close != m_rel) && k < 400) begin
      drive(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, a);
      k++;
    end
    if (sb.size() != 0 || m_close != m_rel)
      check_val("drain_timeout", sb.size() + m_close - m_rel, 0);
  endtask

  task automatic async_reset();
    #2 ireset_n = 1'b0;
    ival = 1'b0;
    #1;
    check_val("rst_ordy", ordy, 1);
    check_val("rst_oval", oval, 0);
    check_val("rst_ooverflow", ooverflow, 0);
    m_in_col = 1'b0;
    m_ovf = 1'b0;
    m_buf.delete();
    @(posedge iclk); #1;
    ireset_n = 1'b1;
  endtask

  // Monitor: edge bookkeeping on posedge, output sampling on negedge.
  initial begin
    exp_t e;
    forever begin
      @(posedge iclk);
      cyc++;
      en_at_edge = iclkena;
      if (iclkena && m_done) begin
        m_done = 1'b0;
        m_rel++;
      end
      @(negedge iclk);
      if (!ireset_n) begin
        sb.delete();
        m_done = 1'b0;
        m_rel = m_close;
      end else if (en_at_edge && oval) begin
        if (sb.size() == 0) begin
          check_val("oval_unexpected", oval, 0);
        end else begin
          e = sb.pop_front();
          check_val("ovnode", ovnode, e.v);
          check_val("osop", osop, e.sop);
          check_val("oeop", oeop, e.eop);
          if (e.eop) begin
            check_val("ohd", ohd, e.hd);
            m_done = 1'b1;
          end
          if (e.sop) check_val("first_latency", cyc - m_eop_cyc, 3);
        end
      end
    end
  end

  initial begin
    bit a;
    int q[$];
    int n, lr;

    repeat (2) @(posedge iclk);
    #1;
    check_val("rst_ordy", ordy, 1);
    check_val("rst_oval", oval, 0);
    check_val("rst_osop", osop, 0);
    check_val("rst_oeop", oeop, 0);
    check_val("rst_ohd", ohd, 0);
    check_val("rst_ooverflow", ooverflow, 0);
    ireset_n = 1'b1;
    idle(2);

    q = '{2, -1, 4};     send_col(3, q);  wait_drain();
    q = '{-15, -15};     send_col(-7, q); wait_drain();
    q = '{-5};           send_col(1, q);  wait_drain();

    // Beats without isop in IDLE are dropped.
    drive(1'b1, 1'b0, 1'b0, 5, 0, 1'b1, a);
    drive(1'b1, 1'b0, 1'b1, -3, 0, 1'b1, a);
    q = '{7, -8, -16, 3}; send_col(2, q);
    // isop mid-column restarts it.
    send(1'b1, 1'b0, 4, -2);
    send(1'b0, 1'b0, 6, 0);
    send(1'b1, 1'b0, -3, 5);
    send(1'b0, 1'b1, 2, 0);
    wait_drain();

    // Truncation at ROW_MAX beats; the trailing beat lands in FLUSH.
    lr = int'($urandom_range(0, 15)) - 8;
    for (int i = 0; i < ROW_MAX; i++) send(i == 0, 1'b0, int'($urandom_range(0, 31)) - 16, lr);
    drive(1'b1, 1'b0, 1'b0, 9, 0, 1'b1, a);
    wait_drain();

    // Clock-enable stall mid-flush with ignored input pulses.
    q = '{1, 2, 3, 4, 5}; send_col(-3, q);
    drive(1'b1, 1'b0, 1'b0, 7, 0, 1'b1, a);
    drive(1'b1, 1'b1, 1'b0, -7, 3, 1'b1, a);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 6, 2, 1'b0, a);
    wait_drain();

    // Reset during ACC, then a clean column.
    send(1'b1, 1'b0, 3, 2);
    send(1'b0, 1'b0, -4, 0);
    async_reset();
    q = '{-6, 1}; send_col(5, q); wait_drain();

    // Reset during FLUSH: no residue of the column may appear.
    q = '{1, 1, 1, 1, 1, 1}; send_col(2, q);
    idle(3);
    async_reset();
    idle(10);

    for (int k = 0; k < 8; k++) begin
      n = int'($urandom_range(1, 8));
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(int'($urandom_range(0, 31)) - 16);
      send_col(int'($urandom_range(0, 15)) - 8, q);
      idle(int'($urandom_range(0, 2)));
    end
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
